item_spawner_lfsr: RTL and testbench

- Parametrised successor to the reward-item random generator.
- Decides when a reward item appears, its type, and its grid position, all from one LFSR running on the system clock.
- Offers the candidate to the map/placement logic through a require/finish/reject handshake, and retries on occupied cells.
- Keeps the item visible for a bounded time or until a tank collects it; sits between the game-tick divider and the map/collision block.

---
 rtl/item_pkg.sv | 40 ++++
 rtl/lfsr_galois.sv | 45 ++++
 rtl/item_spawner_lfsr.sv | 229 ++++++++++++++++++++++
 tb/tb_item_spawner_lfsr.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/item_pkg.sv
// ============================================================================
// item_pkg : shared item codes, spawner FSM states and LFSR constants
// rev 1.0
// ============================================================================
`default_nettype none

package item_pkg;

  typedef enum logic [2:0] {
    ITEM_NONE = 3'd0,
    ITEM_1    = 3'd1,
    ITEM_2    = 3'd2,
    ITEM_3    = 3'd3,
    ITEM_4    = 3'd4
  } item_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DRAW = 3'd2,
    ST_REQ  = 3'd3,
    ST_SHOW = 3'd4
  } state_t;

  // Right-shifting Galois feedback mask for the maximal-length 16-bit polynomial.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic item_t classify(input logic [7:0] r,
                                     input logic [7:0] t1,
                                     input logic [7:0] t2,
                                     input logic [7:0] t3);
    if (r < t1)      return ITEM_1;
    else if (r < t2) return ITEM_2;
    else if (r < t3) return ITEM_3;
    else             return ITEM_4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_galois.sv
// ============================================================================
// lfsr_galois : free-running Galois LFSR with zero-state recovery to SEED
// rev 1.0
// ============================================================================
`default_nettype none

module lfsr_galois
  import item_pkg::*;
#(
  parameter int               LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  wire  [LFSR_W-1:0] lfsr_cur;

  // All next-state logic reads through this net so the current value has a single source.
  assign lfsr_cur = lfsr_q;
  assign lfsr     = lfsr_cur;

  always_comb begin
    lfsr_d = lfsr_cur >> 1;
    if (lfsr_cur == '0) begin
      lfsr_d = SEED;
    end else if (lfsr_cur[0]) begin
      lfsr_d = (lfsr_cur >> 1) ^ LFSR_W'(LFSR_TAPS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/item_spawner_lfsr.sv
// ============================================================================
// item_spawner_lfsr : LFSR-timed reward item spawner with map handshake
// rev 1.0
// ============================================================================
`default_nettype none

module item_spawner_lfsr
  import item_pkg::*;
#(
  parameter int               LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int               X_W       = 5,
  parameter int               Y_W       = 5,
  parameter int               X_MIN     = 4,
  parameter int               X_RANGE_W = 4,
  parameter int               Y_MIN     = 2,
  parameter int               Y_RANGE_W = 3,
  parameter int               BASE_TIME = 20,
  parameter int               JITTER_W  = 7,
  parameter int               STAY_TIME = 40,
  parameter int               MAX_RETRY = 3,
  parameter int               T1        = 32,
  parameter int               T2        = 96,
  parameter int               T3        = 160
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           enable,
  input  logic           set_finish,
  input  logic           set_reject,
  input  logic           item_taken,
  output logic           set_require,
  output logic           item_active,
  output logic [2:0]     item_type,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  output logic           give_up
);

  localparam int DLY_MAX = BASE_TIME + (2 ** JITTER_W) - 1;
  localparam int DLY_W   = $clog2(DLY_MAX + 2);
  localparam int STAY_W  = $clog2(STAY_TIME + 2);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  if (LFSR_W != 16) begin : g_chk_lfsr_w
    $error("item_spawner_lfsr: LFSR_W must be 16");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("item_spawner_lfsr: SEED must be nonzero");
  end
  if (JITTER_W < 1 || JITTER_W > LFSR_W) begin : g_chk_jitter
    $error("item_spawner_lfsr: JITTER_W out of range");
  end
  if (X_MIN + (2 ** X_RANGE_W) - 1 >= (2 ** X_W)) begin : g_chk_x_fit
    $error("item_spawner_lfsr: column range does not fit in X_W");
  end
  if (Y_RANGE_W > 8 || Y_MIN + (2 ** Y_RANGE_W) - 1 >= (2 ** Y_W)) begin : g_chk_y_fit
    $error("item_spawner_lfsr: row range does not fit in Y_W");
  end
  if (STAY_TIME < 1) begin : g_chk_stay
    $error("item_spawner_lfsr: STAY_TIME must be at least 1");
  end

  logic [LFSR_W-1:0] lfsr;

  lfsr_galois #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // Candidate fields and fresh delay are pure functions of the current LFSR word.
  logic [X_W-1:0]   draw_x;
  logic [Y_W-1:0]   draw_y;
  item_t            draw_type;
  logic [DLY_W-1:0] new_delay;
  logic             unused_lfsr_bits;

  assign draw_x           = X_W'(X_MIN) + X_W'(lfsr[X_RANGE_W-1:0]);
  assign draw_y           = Y_W'(Y_MIN) + Y_W'(lfsr[8 +: Y_RANGE_W]);
  assign draw_type        = classify(lfsr[15:8], 8'(T1), 8'(T2), 8'(T3));
  assign new_delay        = DLY_W'(BASE_TIME) + DLY_W'(lfsr[JITTER_W-1:0]);
  assign unused_lfsr_bits = ^lfsr;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [STAY_W-1:0] stay_q, stay_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic              set_require_q, set_require_d;
  logic              item_active_q, item_active_d;
  item_t             item_type_q, item_type_d;
  logic [X_W-1:0]    xpos_q, xpos_d;
  logic [Y_W-1:0]    ypos_q, ypos_d;
  logic              give_up_q, give_up_d;

  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    stay_d        = stay_q;
    rty_d         = rty_q;
    set_require_d = set_require_q;
    item_active_d = item_active_q;
    item_type_d   = item_type_q;
    xpos_d        = xpos_q;
    ypos_d        = ypos_q;
    give_up_d     = 1'b0;

    if (!enable) begin
      state_d       = ST_IDLE;
      dly_d         = '0;
      stay_d        = '0;
      rty_d         = '0;
      set_require_d = 1'b0;
      item_active_d = 1'b0;
      item_type_d   = ITEM_NONE;
      xpos_d        = '0;
      ypos_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          dly_d   = new_delay;
        end

        ST_WAIT: begin
          if (tick) begin
            if (dly_q <= DLY_W'(1)) begin
              dly_d   = '0;
              rty_d   = '0;
              state_d = ST_DRAW;
            end else begin
              dly_d = dly_q - DLY_W'(1);
            end
          end
        end

        ST_DRAW: begin
          xpos_d        = draw_x;
          ypos_d        = draw_y;
          item_type_d   = draw_type;
          set_require_d = 1'b1;
          state_d       = ST_REQ;
        end

        ST_REQ: begin
          // Acceptance takes priority over a simultaneous reject.
          if (set_finish) begin
            set_require_d = 1'b0;
            item_active_d = 1'b1;
            stay_d        = STAY_W'(STAY_TIME);
            state_d       = ST_SHOW;
          end else if (set_reject) begin
            set_require_d = 1'b0;
            if (rty_q < RTY_W'(MAX_RETRY)) begin
              rty_d   = rty_q + RTY_W'(1);
              state_d = ST_DRAW;
            end else begin
              give_up_d   = 1'b1;
              item_type_d = ITEM_NONE;
              xpos_d      = '0;
              ypos_d      = '0;
              dly_d       = new_delay;
              state_d     = ST_WAIT;
            end
          end
        end

        ST_SHOW: begin
          if (tick && stay_q > STAY_W'(1)) begin
            stay_d = stay_q - STAY_W'(1);
          end
          if (item_taken || (tick && stay_q <= STAY_W'(1))) begin
            stay_d        = '0;
            item_active_d = 1'b0;
            item_type_d   = ITEM_NONE;
            xpos_d        = '0;
            ypos_d        = '0;
            dly_d         = new_delay;
            state_d       = ST_WAIT;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dly_q         <= '0;
      stay_q        <= '0;
      rty_q         <= '0;
      set_require_q <= 1'b0;
      item_active_q <= 1'b0;
      item_type_q   <= ITEM_NONE;
      xpos_q        <= '0;
      ypos_q        <= '0;
      give_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      stay_q        <= stay_d;
      rty_q         <= rty_d;
      set_require_q <= set_require_d;
      item_active_q <= item_active_d;
      item_type_q   <= item_type_d;
      xpos_q        <= xpos_d;
      ypos_q        <= ypos_d;
      give_up_q     <= give_up_d;
    end
  end

  assign set_require = set_require_q;
  assign item_active = item_active_q;
  assign item_type   = item_type_q;
  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign give_up     = give_up_q;

endmodule

`default_nettype wire

// File: tb/tb_item_spawner_lfsr.sv
// ============================================================================
// tb_item_spawner_lfsr : directed + randomized self-checking bench for the spawner
// rev 1.0
// ============================================================================
`default_nettype none

module tb_item_spawner_lfsr;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int BASE = 3;
  localparam int STAY = 5;

  logic       clk = 1'b0;
  logic       rst_n, tick, enable, set_finish, set_reject, item_taken;
  logic       set_require, item_active, give_up;
  logic [2:0] item_type;
  logic [4:0] xpos, ypos;

  always #5 clk = ~clk;

  item_spawner_lfsr #(
    .SEED      (SEED),
    .BASE_TIME (BASE),
    .JITTER_W  (1),
    .STAY_TIME (STAY),
    .MAX_RETRY (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .enable      (enable),
    .set_finish  (set_finish),
    .set_reject  (set_reject),
    .item_taken  (item_taken),
    .set_require (set_require),
    .item_active (item_active),
    .item_type   (item_type),
    .xpos        (xpos),
    .ypos        (ypos),
    .give_up     (give_up)
  );

  int          npass = 0;
  int          ntot  = 0;
  int          nfail = 0;
  logic [15:0] lf;
  logic [15:0] pre;
  logic [12:0] cur;
  int          d_exp;
  int          hist [4];
  int          n_draw = 0;
  int          range_bad = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    if (v == 16'h0) return SEED;
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Expected candidate {type, x, y} for a given LFSR word.
  function automatic logic [12:0] cand(input logic [15:0] v);
    int r, x, y;
    logic [2:0] typ;
    r   = int'(v) / 256;
    x   = 4 + int'(v) % 16;
    y   = 2 + r % 8;
    typ = (r < 32) ? 3'd1 : (r < 96) ? 3'd2 : (r < 160) ? 3'd3 : 3'd4;
    return {typ, 5'(x), 5'(y)};
  endfunction

  function automatic logic [15:0] obs();
    return {set_require, item_active, item_type, xpos, ypos, give_up};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit t, input bit fin, input bit rej, input bit tk);
    tick       = t;
    set_finish = fin;
    set_reject = rej;
    item_taken = tk;
    pre        = lf;
    @(posedge clk);
    lf = rst_n ? lfsr_next(lf) : SEED;
    #1;
    tick       = 1'b0;
    set_finish = 1'b0;
    set_reject = 1'b0;
    item_taken = 1'b0;
  endtask

  task automatic wait_phase(input int d, input string tag);
    int left;
    left = d;
    for (int i = 0; i < 200 && left > 0; i++) begin
      bit t;
      t = ($urandom_range(3) != 0);
      cyc(t, rb(), rb(), rb());
      if (t) left--;
      chk({tag, "_wait"}, obs(), 16'h0000);
    end
    chk({tag, "_wait_bound"}, 16'(left), 16'h0000);
  endtask

  task automatic draw_check(input string tag);
    cyc(rb(), rb(), rb(), rb());
    cur = cand(pre);
    chk(tag, obs(), {1'b1, 1'b0, cur, 1'b0});
    n_draw++;
    if (item_type >= 3'd1 && item_type <= 3'd4) hist[item_type - 3'd1]++;
    if (xpos < 5'd4 || xpos > 5'd19 || ypos < 5'd2 || ypos > 5'd9) range_bad++;
  endtask

  task automatic reject_once(input string tag, input bit expect_gu);
    cyc(rb(), 1'b0, 1'b1, rb());
    if (expect_gu) begin
      chk(tag, obs(), 16'h0001);
      d_exp = BASE + int'(pre[0]);
    end else begin
      chk(tag, {13'h0, set_require, item_active, give_up}, 16'h0000);
    end
  endtask

  task automatic finish_now(input string tag);
    cyc(rb(), 1'b1, rb(), rb());
    chk(tag, obs(), {1'b0, 1'b1, cur, 1'b0});
  endtask

  // take_tick: 0 = run to expiry, k = item_taken together with the k-th tick.
  task automatic show_phase(input string tag, input int take_tick);
    int seen;
    bit done;
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      bit t, tk;
      t  = rb();
      tk = 1'b0;
      if (take_tick != 0 && seen + 1 == take_tick) begin
        t  = 1'b1;
        tk = 1'b1;
      end
      cyc(t, rb(), rb(), tk);
      if (t) seen++;
      if (tk || (t && seen == STAY)) begin
        done  = 1'b1;
        d_exp = BASE + int'(pre[0]);
        chk({tag, "_exit"}, obs(), 16'h0000);
      end else begin
        chk({tag, "_hold"}, obs(), {1'b0, 1'b1, cur, 1'b0});
      end
    end
    chk({tag, "_bound"}, 16'(done), 16'h0001);
  endtask

  task automatic reenable(input string tag);
    enable = 1'b1;
    cyc(rb(), rb(), rb(), rb());
    d_exp = BASE + int'(pre[0]);
    chk(tag, obs(), 16'h0000);
  endtask

  initial begin
    int e [4];
    e = '{32, 64, 64, 96};
    for (int k = 0; k < 4; k++) hist[k] = 0;
    rst_n = 1'b0; enable = 1'b0; tick = 1'b0;
    set_finish = 1'b0; set_reject = 1'b0; item_taken = 1'b0;
    lf = SEED;
    #3;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_out", obs(), 16'h0000);
    chk("reset_lfsr", dut.lfsr, SEED);
    rst_n = 1'b1;
    repeat (3) cyc(rb(), rb(), rb(), rb());
    chk("idle_out", obs(), 16'h0000);
    chk("lfsr_track", dut.lfsr, lf);

    // First item: accept on the first REQ clk (reject in same clk), run to expiry.
    reenable("en_a");
    wait_phase(d_exp, "a");
    draw_check("a_cand");
    finish_now("a_fin");
    show_phase("a_show", 0);

    // Three rejects then accept; item taken on second tick.
    wait_phase(d_exp, "b");
    draw_check("b_cand0");
    for (int k = 0; k < 3; k++) begin
      reject_once("b_rej", 1'b0);
      draw_check("b_cand");
    end
    finish_now("b_fin");
    show_phase("b_take2", 2);

    // Four rejects give up; then take coincides with the final tick.
    wait_phase(d_exp, "c");
    draw_check("c_cand0");
    for (int k = 0; k < 3; k++) begin
      reject_once("c_rej", 1'b0);
      draw_check("c_cand");
    end
    reject_once("c_give_up", 1'b1);
    wait_phase(d_exp, "c2");
    draw_check("c2_cand");
    finish_now("c2_fin");
    show_phase("c2_same_clk", STAY);

    // enable dropped in REQ and in SHOW.
    wait_phase(d_exp, "d");
    draw_check("d_cand");
    enable = 1'b0;
    cyc(rb(), rb(), rb(), rb());
    chk("d_drop_req", obs(), 16'h0000);
    cyc(1'b1, rb(), rb(), rb());
    chk("d_idle", obs(), 16'h0000);
    reenable("d_en");
    wait_phase(d_exp, "d2");
    draw_check("d2_cand");
    finish_now("d2_fin");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("d2_show", obs(), {1'b0, 1'b1, cur, 1'b0});
    enable = 1'b0;
    cyc(rb(), rb(), rb(), rb());
    chk("d_drop_show", obs(), 16'h0000);
    reenable("d3_en");

    // Asynchronous reset in the middle of SHOW.
    wait_phase(d_exp, "r");
    draw_check("r_cand");
    finish_now("r_fin");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", obs(), 16'h0000);
    lf = SEED;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    enable = 1'b0;
    chk("rst_lfsr", dut.lfsr, SEED);
    repeat (2) cyc(rb(), rb(), rb(), rb());
    chk("rst_idle", obs(), 16'h0000);

    // Zero-state recovery of the LFSR.
    force dut.u_lfsr.lfsr_cur = 16'h0000;
    @(posedge clk);
    #1;
    release dut.u_lfsr.lfsr_cur;
    #1;
    lf = SEED;
    chk("lfsr_zero_reload", dut.lfsr, SEED);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lfsr_after_reload", dut.lfsr, lf);

    // Long randomized run: 2500 rounds of four candidates each.
    n_draw    = 0;
    range_bad = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    reenable("h_en");
    for (int r = 0; r < 2500; r++) begin
      wait_phase(d_exp, "h");
      draw_check("h_cand");
      for (int k = 0; k < 3; k++) begin
        reject_once("h_rej", 1'b0);
        draw_check("h_cand");
      end
      reject_once("h_give_up", 1'b1);
    end
    chk("xy_range", 16'(range_bad), 16'h0000);
    for (int k = 0; k < 4; k++) begin
      int diff;
      diff = hist[k] * 256 - e[k] * n_draw;
      if (diff < 0) diff = -diff;
      chk($sformatf("hist_type%0d", k + 1), 16'(diff * 20 <= 256 * n_draw), 16'h0001);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
